lc3_pipe_ctrl: RTL and testbench
================================

LC3_PIPE_CTRL -- requirements
Module: lc3_pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: the maximum number of cycles to wait for any memory completion.
REQ-002 SHALL have port clock, input, 1 bit: the rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port imem_done, input, 1 bit: the instruction memory read has completed.
REQ-005 SHALL have port dmem_done, input, 1 bit: the data memory access has completed.
REQ-006 SHALL have port ir, input, 16 bits: the instruction word, valid from DECODE onward.
REQ-007 SHALL have port nzp_in, input, 3 bits: the condition flags from writeback.
REQ-008 SHALL have the following 1-bit output ports: enable_fetch, enable_decode, enable_execute, enable_writeback and enable_updatepc, one strobe per stage.
REQ-009 SHALL have port br_taken, output, 1 bit: selects taddr in the fetch unit.
REQ-010 SHALL have port mem_state, output, 2 bits: 0=read, 1=write, 2=indirect read, 3=idle.
REQ-011 SHALL have port instr_count, output, 16 bits: the count of retired instructions.
REQ-012 SHALL have port mem_err, output, 1 bit: a sticky memory timeout flag.

Function
REQ-013 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM_IND, MEM, WB and UPDPC, with all strobes decoded combinationally from the state register (Moore).
REQ-014 SHALL move IDLE->FETCH unconditionally; this is the first cycle after reset is released.
REQ-015 SHALL assert enable_fetch in FETCH and hold FETCH until imem_done=1, then move to DECODE.
REQ-016 SHALL assert enable_decode for exactly one cycle in DECODE, then move to EXEC.
REQ-017 SHALL assert enable_execute for one cycle in EXEC, with the next state set by opcode ir[15:12]:
- LD(0010), LDR(0110): MEM with mem_state=0.
- ST(0011), STR(0111): MEM with mem_state=1.
- LDI(1010), STI(1011): MEM_IND with mem_state=2.
- ADD(0001), AND(0101), NOT(1001), LEA(1110): WB.
- BR(0000), JMP(1100), all other opcodes: UPDPC.
REQ-018 SHALL hold MEM_IND until dmem_done, then move to MEM with mem_state=0 for LDI or 1 for STI.
REQ-019 SHALL hold MEM until dmem_done, then go to WB for loads and to UPDPC for stores.
REQ-020 SHALL drive mem_state=3 in every state other than MEM_IND and MEM.
REQ-021 SHALL assert enable_writeback for one cycle in WB, then move to UPDPC.
REQ-022 SHALL assert enable_updatepc for one cycle in UPDPC, then return to FETCH.
REQ-023 SHALL drive br_taken=1 in UPDPC only when:
- the opcode is JMP, or
- the opcode is BR and (ir[11:9] & nzp_reg) != 0.
- br_taken SHALL be 0 in all other cases.
REQ-024 SHALL hold nzp_reg at 3'b010 after reset and load it from nzp_in on the clock edge that ends WB.
REQ-025 SHALL increment instr_count on the edge leaving UPDPC, wrapping from 16'hFFFF to 0.
REQ-026 SHALL reset the wait counter on entry to FETCH, MEM_IND or MEM; if the counter reaches MEM_TIMEOUT without the matching done, it SHALL set mem_err=1 and advance as if done were seen.
REQ-027 SHALL ignore a done signal that arrives in any state other than the one waiting for it.
REQ-028 SHALL take the transition in the same cycle when done and timeout occur together, and SHALL still set mem_err.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, all strobes 0, br_taken=0, mem_state=3, instr_count=0, mem_err=0, nzp_reg=3'b010 and the wait counter to 0.
REQ-030 SHALL abort any in-flight instruction when reset is asserted in any state, with no strobe asserted on the following cycle.

Configuration
REQ-031 SHALL, when LC3_TRAP_HALT_EN is defined, decode TRAP(1111) in EXEC to a terminal HALT state with all strobes 0, output halted=1, and no exit except reset.
REQ-032 SHALL, when LC3_TRAP_HALT_EN is undefined, have no halted port and treat TRAP as a NOP (EXEC->UPDPC, br_taken=0).

Structure
REQ-033 SHALL place the state enum, the opcode localparams and the mem_state encodings in the shared package lc3_pkg.
REQ-034 SHALL implement the wait/timeout counter as the sub-module lc3_mem_timer, with inputs clear and done and output expired.

Verification
REQ-035 SHALL cover ADD: ir=16'h1261, imem_done on the 2nd FETCH cycle -> state sequence FETCH(2) DEC EXEC WB UPDPC, br_taken=0, instr_count=1.
REQ-036 SHALL cover LDI: ir=16'hA405, dmem_done after 3 cycles in each wait state -> mem_state 2 then 0, WB occurs, total 13 cycles.
REQ-037 SHALL cover BRz: ir=16'h0403 with nzp_reg=010 -> br_taken=1 in UPDPC; with nzp_reg=100 -> br_taken=0.
REQ-038 SHALL cover timeout: MEM_TIMEOUT=4, STR with dmem_done held at 0 -> MEM exits after 4 cycles, mem_err=1 and stays 1.
REQ-039 SHALL cover reset mid-instruction: reset asserted in MEM -> IDLE next cycle, instr_count=0, FETCH on the cycle after release.
REQ-040 SHALL cover wrap: preload 65535 retirements -> instr_count wraps to 0; TRAP 16'hF025 -> halted with the macro, NOP without it.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 pipeline controller: state encoding, opcodes, memory modes.
// The HALT state exists only when LC3_TRAP_HALT_EN is defined.
package lc3_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_IND,
        S_MEM,
        S_WB,
        S_UPDPC
`ifdef LC3_TRAP_HALT_EN
        ,
        S_HALT
`endif
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_WRITE = 2'd1;
    localparam logic [1:0] MS_IND   = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

endpackage

// File: rtl/lc3_mem_timer.sv
// Wait-state counter: counts cycles spent in a memory wait and flags when MEM_TIMEOUT is reached.
// expired rises during the MEM_TIMEOUT-th cycle after the last clear.
module lc3_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic done,
    output logic expired
);
    import lc3_pkg::*;

    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (!done && !expired) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// Multi-cycle LC-3 control FSM: sequences fetch/decode/execute/memory/writeback/PC-update strobes.
// Define LC3_TRAP_HALT_EN to make TRAP enter a terminal HALT state and add the halted output.
module lc3_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_done,
    input  logic        dmem_done,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp_in,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatepc,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic [15:0] instr_count,
    output logic        mem_err
`ifdef LC3_TRAP_HALT_EN
    ,
    output logic        halted
`endif
);
    import lc3_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic        r_isStore;
    logic [2:0]  r_nzp;
    logic [15:0] r_instrCount;
    logic        r_memErr;

    logic [3:0]  w_op;
    logic        w_waiting;
    logic        w_done;
    logic        w_expired;
    logic        w_advance;
    logic        w_clear;
    logic        w_unusedIr;

    assign w_op       = ir[15:12];
    assign w_unusedIr = ^ir[8:0];

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_IND) || (r_state == S_MEM);
    assign w_done    = (r_state == S_FETCH) ? imem_done :
                       ((r_state == S_MEM_IND) || (r_state == S_MEM)) ? dmem_done : 1'b0;
    assign w_advance = w_done || w_expired;
    // Any state change restarts the wait count, so each wait state starts from zero.
    assign w_clear   = (w_next != r_state);

    lc3_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_clear),
        .done    (w_done),
        .expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        enable_updatepc  = 1'b0;
        br_taken         = 1'b0;
        mem_state        = MS_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                enable_fetch = 1'b1;
                if (w_advance) w_next = S_DECODE;
            end
            S_DECODE: begin
                enable_decode = 1'b1;
                w_next        = S_EXEC;
            end
            S_EXEC: begin
                enable_execute = 1'b1;
                case (w_op)
                    OP_LD, OP_LDR, OP_ST, OP_STR:   w_next = S_MEM;
                    OP_LDI, OP_STI:                 w_next = S_MEM_IND;
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: w_next = S_WB;
`ifdef LC3_TRAP_HALT_EN
                    OP_TRAP:                        w_next = S_HALT;
`else
                    OP_TRAP:                        w_next = S_UPDPC;
`endif
                    default:                        w_next = S_UPDPC;
                endcase
            end
            S_MEM_IND: begin
                mem_state = MS_IND;
                if (w_advance) w_next = S_MEM;
            end
            S_MEM: begin
                mem_state = r_isStore ? MS_WRITE : MS_READ;
                if (w_advance) w_next = r_isStore ? S_UPDPC : S_WB;
            end
            S_WB: begin
                enable_writeback = 1'b1;
                w_next           = S_UPDPC;
            end
            S_UPDPC: begin
                enable_updatepc = 1'b1;
                br_taken        = (w_op == OP_JMP) ||
                                  ((w_op == OP_BR) && ((ir[11:9] & r_nzp) != 3'b000));
                w_next          = S_FETCH;
            end
`ifdef LC3_TRAP_HALT_EN
            S_HALT:   w_next = S_HALT;
`endif
            default:  w_next = S_IDLE;
        endcase
        if (reset) begin
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
            enable_updatepc  = 1'b0;
            br_taken         = 1'b0;
            mem_state        = MS_IDLE;
        end
    end

    // Store flag, condition codes, retirement count and the sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_isStore    <= 1'b0;
            r_nzp        <= 3'b010;
            r_instrCount <= 16'd0;
            r_memErr     <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_isStore <= (w_op == OP_ST) || (w_op == OP_STR) || (w_op == OP_STI);
            end
            if (r_state == S_WB) begin
                r_nzp <= nzp_in;
            end
            if (r_state == S_UPDPC) begin
                r_instrCount <= r_instrCount + 16'd1;
            end
            if (w_waiting && w_expired) begin
                r_memErr <= 1'b1;
            end
        end
    end

    assign instr_count = r_instrCount;
    assign mem_err     = r_memErr;
`ifdef LC3_TRAP_HALT_EN
    assign halted      = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Randomized self-checking bench for lc3_pipe_ctrl; expected cycle traces come from an instruction-level model.
// Honours LC3_TRAP_HALT_EN the same way as the design.
module tb_lc3_pipe_ctrl;

    localparam int T = 4;

    localparam logic [4:0] EF = 5'b10000;
    localparam logic [4:0] ED = 5'b01000;
    localparam logic [4:0] EE = 5'b00100;
    localparam logic [4:0] EW = 5'b00010;
    localparam logic [4:0] EU = 5'b00001;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_done;
    logic        dmem_done;
    logic [15:0] ir;
    logic [2:0]  nzp_in;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatepc;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic [15:0] instr_count;
    logic        mem_err;
`ifdef LC3_TRAP_HALT_EN
    logic        halted;
`endif

    int          total = 0;
    int          bad = 0;
    int          cycles = 0;
    int          nzpSel = -1;
    logic [15:0] mCount;
    logic        mErr;
    logic [2:0]  mNzp;
    logic        mHalt;

    lc3_pipe_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_done        (imem_done),
        .dmem_done        (dmem_done),
        .ir               (ir),
        .nzp_in           (nzp_in),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatepc  (enable_updatepc),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
        .instr_count      (instr_count),
        .mem_err          (mem_err)
`ifdef LC3_TRAP_HALT_EN
        ,
        .halted           (halted)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction class: 0 load, 1 store, 2 indirect load, 3 indirect store, 4 ALU, 5 PC-only, 6 halt.
    function automatic int opClass(input logic [3:0] op);
        case (op)
            4'h2, 4'h6:             return 0;
            4'h3, 4'h7:             return 1;
            4'hA:                   return 2;
            4'hB:                   return 3;
            4'h1, 4'h5, 4'h9, 4'hE: return 4;
`ifdef LC3_TRAP_HALT_EN
            4'hF:                   return 6;
`endif
            default:                return 5;
        endcase
    endfunction

    function automatic logic [4:0] strobes();
        return {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatepc};
    endfunction

    // One clock cycle: drive inputs, check the current outputs, then advance the model past the edge.
    task automatic applyStimulus(input logic [4:0] en, input logic [1:0] ms, input logic br,
                                 input logic imem, input logic dmem,
                                 input bit errAfter, input bit incAfter, input bit wb);
        imem_done = imem;
        dmem_done = dmem;
        nzp_in    = (nzpSel >= 0) ? nzpSel[2:0] : 3'($urandom);
        checkOutput("strobes", {27'd0, strobes()}, {27'd0, en});
        checkOutput("mem_state", {30'd0, mem_state}, {30'd0, ms});
        checkOutput("br_taken", {31'd0, br_taken}, {31'd0, br});
        checkOutput("instr_count", {16'd0, instr_count}, {16'd0, mCount});
        checkOutput("mem_err", {31'd0, mem_err}, {31'd0, mErr});
`ifdef LC3_TRAP_HALT_EN
        checkOutput("halted", {31'd0, halted}, {31'd0, mHalt});
`endif
        @(posedge clock);
        if (errAfter) mErr = 1'b1;
        if (incAfter) mCount = mCount + 16'd1;
        if (wb) mNzp = nzp_in;
        cycles++;
        @(negedge clock);
    endtask

    task automatic applyReset(input logic [15:0] preload, input bit doPreload);
        reset     = 1'b1;
        imem_done = 1'b0;
        dmem_done = 1'b0;
        @(posedge clock);
        @(negedge clock);
        mCount = 16'd0;
        mErr   = 1'b0;
        mNzp   = 3'b010;
        mHalt  = 1'b0;
        checkOutput("rst_strobes", {27'd0, strobes()}, 32'd0);
        checkOutput("rst_mem_state", {30'd0, mem_state}, 32'd3);
        checkOutput("rst_br", {31'd0, br_taken}, 32'd0);
        checkOutput("rst_count", {16'd0, instr_count}, 32'd0);
        checkOutput("rst_err", {31'd0, mem_err}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("idle_strobes", {27'd0, strobes()}, 32'd0);
        if (doPreload) force dut.r_instrCount = preload;
        @(posedge clock);
        #1;
        if (doPreload) begin
            release dut.r_instrCount;
            mCount = preload;
        end
        @(negedge clock);
    endtask

    // Plays one instruction: df/dm1/dm2 are the 0-based cycle in each wait state where done pulses.
    task automatic runInstr(input logic [15:0] instr, input int df, input int dm1, input int dm2);
        logic [3:0] op;
        int         cls;
        int         n;
        logic       br;
        op     = instr[15:12];
        cls    = opClass(op);
        ir     = instr;
        cycles = 0;
        n = (df + 1 < T) ? df + 1 : T;
        for (int i = 0; i < n; i++)
            applyStimulus(EF, 2'd3, 1'b0, (i == df), rnd(), (i == n - 1) && (df + 1 >= T), 1'b0, 1'b0);
        applyStimulus(ED, 2'd3, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        applyStimulus(EE, 2'd3, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        if (cls == 6) begin
            mHalt = 1'b1;
            for (int i = 0; i < 5; i++)
                applyStimulus(5'd0, 2'd3, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
            return;
        end
        if (cls == 2 || cls == 3) begin
            n = (dm1 + 1 < T) ? dm1 + 1 : T;
            for (int i = 0; i < n; i++)
                applyStimulus(5'd0, 2'd2, 1'b0, rnd(), (i == dm1), (i == n - 1) && (dm1 + 1 >= T), 1'b0, 1'b0);
        end
        if (cls <= 3) begin
            n = (dm2 + 1 < T) ? dm2 + 1 : T;
            for (int i = 0; i < n; i++)
                applyStimulus(5'd0, (cls == 1 || cls == 3) ? 2'd1 : 2'd0, 1'b0, rnd(), (i == dm2),
                              (i == n - 1) && (dm2 + 1 >= T), 1'b0, 1'b0);
        end
        if (cls == 0 || cls == 2 || cls == 4)
            applyStimulus(EW, 2'd3, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b1);
        br = (op == 4'hC) || ((op == 4'h0) && ((instr[11:9] & mNzp) != 3'b000));
        applyStimulus(EU, 2'd3, br, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        imem_done = 1'b0;
        dmem_done = 1'b0;
        ir        = 16'h0000;
        nzp_in    = 3'b000;
        @(negedge clock);
        applyReset(16'd0, 1'b0);

        runInstr(16'h1261, 1, 0, 0);
        checkOutput("add_count", {16'd0, instr_count}, 32'd1);

        runInstr(16'hA405, 2, 2, 2);
        checkOutput("ldi_cycles", cycles, 32'd13);

        applyReset(16'd0, 1'b0);
        runInstr(16'h0403, 0, 0, 0);
        nzpSel = 4;
        runInstr(16'h1261, 0, 0, 0);
        nzpSel = -1;
        runInstr(16'h0403, 0, 0, 0);
        runInstr(16'hC1C0, 1, 0, 0);

        ir = 16'h7081;
        applyStimulus(EF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(ED, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(EE, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyReset(16'd0, 1'b0);
        runInstr(16'h1261, 0, 0, 0);

        runInstr(16'h7081, 0, 0, 100);
        checkOutput("timeout_err", {31'd0, mem_err}, 32'd1);
        runInstr(16'h1261, 0, 0, 0);

        applyReset(16'hFFFE, 1'b1);
        runInstr(16'h1261, 0, 0, 0);
        runInstr(16'h0E01, 0, 0, 0);
        checkOutput("wrap", {16'd0, instr_count}, 32'd0);

        applyReset(16'd0, 1'b0);
        for (int k = 0; k < 80; k++) begin
            logic [3:0] op;
            op = 4'($urandom);
`ifdef LC3_TRAP_HALT_EN
            if (op == 4'hF) op = 4'hE;
`endif
            if (k % 25 == 24) applyReset(16'd0, 1'b0);
            runInstr({op, 12'($urandom)}, int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        applyReset(16'd0, 1'b0);
        runInstr(16'hF025, 0, 0, 0);
`ifndef LC3_TRAP_HALT_EN
        checkOutput("trap_nop", {16'd0, instr_count}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
